// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache refill arbiter:
//   - refill_state_e : refill FSM state encoding
//   - DEF_*          : default parameter values used by the top level
//   - line_off()     : byte-offset width of a refill line
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int DEF_NUM_PE     = 4;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_TAG_WIDTH  = 8;
  localparam int DEF_DATA_WIDTH = 128;
  localparam int DEF_N_WAY      = 4;
  localparam int DEF_MERGE_EN   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_UPD  = 2'd3
  } refill_state_e;

  // Number of address bits that select a byte inside one refill line.
  function automatic int line_off(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/icache_rr_arb.sv
// -----------------------------------------------------------------------------
// icache_rr_arb
// Combinational round-robin pick: the first requester at or above ptr,
// wrapping to the lowest requester when none exists above ptr.
// Ports:
//   req   in   NUM_PE  request vector
//   ptr   in   IDX_W   round-robin start index (always < NUM_PE)
//   gnt   out  NUM_PE  one-hot grant (zero when no request)
//   idx   out  IDX_W   granted index (zero when no request)
//   valid out  1       any request present
// -----------------------------------------------------------------------------
module icache_rr_arb #(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_PE-1:0] gnt,
  output logic [IDX_W-1:0]  idx,
  output logic              valid
);

  logic [IDX_W-1:0] idx_hi;
  logic [IDX_W-1:0] idx_lo;
  logic             found_hi;

  // Scan downward so the last hit written is the lowest index: idx_lo is the
  // lowest requester overall, idx_hi the lowest requester at or above ptr.
  always_comb begin
    idx_hi   = '0;
    idx_lo   = '0;
    found_hi = 1'b0;
    for (int j = NUM_PE - 1; j >= 0; j--) begin
      if (req[j]) begin
        idx_lo = IDX_W'(j);
        if (j >= int'(ptr)) begin
          idx_hi   = IDX_W'(j);
          found_hi = 1'b1;
        end
      end
    end
  end

  assign valid = |req;
  assign idx   = found_hi ? idx_hi : idx_lo;
  assign gnt   = valid ? (NUM_PE'(1) << idx) : '0;

endmodule

// File: rtl/icache_refill_arb.sv
// -----------------------------------------------------------------------------
// icache_refill_arb
// Collects instruction-cache misses from NUM_PE cores, fetches one line at a
// time from memory (round-robin between cores), writes tag + data into the
// victim way and pulses a per-core response. With MERGE_EN, every core that
// is waiting on the same line is answered by the same fetch.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_cache_miss/addr/vic     per-core miss pulse with address and victim way
//   o_resp_miss               per-core one-cycle refill-done pulse
//   o_mm_rden/o_mm_addr       memory read request (held until i_mm_gnt)
//   i_mm_gnt                  memory accepts request this cycle
//   i_mm_rdata/i_mm_rvalid    memory read data return
//   o_inst_tag_*/o_inst_data_* tag/data RAM write port (active in UPD only)
//   o_busy                    FSM not idle or any core pending
// Handshake: o_mm_rden/o_mm_addr stay asserted and stable from entering REQ
// until a cycle with i_mm_gnt=1; i_mm_rvalid is only accepted in WAIT and is
// dropped in every other state.
// -----------------------------------------------------------------------------
module icache_refill_arb
  import icache_pkg::*;
#(
  parameter int NUM_PE     = DEF_NUM_PE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_WAY      = DEF_N_WAY,
  parameter int MERGE_EN   = DEF_MERGE_EN
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_PE-1:0]              i_cache_miss,
  input  logic [NUM_PE-1:0][31:0]        i_addr_miss,
  input  logic [NUM_PE-1:0][N_WAY-1:0]   i_vic_miss,
  output logic [NUM_PE-1:0]              o_resp_miss,
  output logic                           o_mm_rden,
  output logic [31:0]                    o_mm_addr,
  input  logic                           i_mm_gnt,
  input  logic [DATA_WIDTH-1:0]          i_mm_rdata,
  input  logic                           i_mm_rvalid,
  output logic [N_WAY-1:0]               o_inst_tag_upd,
  output logic [ADDR_WIDTH-1:0]          o_inst_tag_addr_upd,
  output logic [TAG_WIDTH-1:0]           o_inst_tag_wdata_upd,
  output logic [DATA_WIDTH-1:0]          o_inst_data_wdata_upd,
  output logic                           o_busy
);

  localparam int OFF    = line_off(DATA_WIDTH);
  localparam int LINE_W = 32 - OFF;
  localparam int IDX_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  // FSM state; state_q is the observable state for checkers.
  refill_state_e state_q, state_d;

  logic [NUM_PE-1:0]             pending_q, pending_d;
  logic [NUM_PE-1:0][LINE_W-1:0] line_q;     // captured line address per core
  logic [NUM_PE-1:0][N_WAY-1:0]  vic_q;
  logic [IDX_W-1:0]              rr_ptr_q;
  logic [IDX_W-1:0]              win_q;
  logic [NUM_PE-1:0]             win_gnt_q;
  logic [DATA_WIDTH-1:0]         data_q;
  logic [NUM_PE-1:0]             resp_q;

  logic [NUM_PE-1:0] arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_valid;

  logic [LINE_W-1:0] win_line;
  logic [NUM_PE-1:0] same_line;
  logic [NUM_PE-1:0] serve;
  logic [NUM_PE-1:0] clear;
  logic [NUM_PE-1:0] set;
  logic              in_upd;

  // Byte-offset bits never matter: requests and compares are line-granular.
  logic unused_offset_bits;
  always_comb begin
    unused_offset_bits = 1'b0;
    for (int p = 0; p < NUM_PE; p++) begin
      unused_offset_bits = unused_offset_bits ^ (^i_addr_miss[p][OFF-1:0]);
    end
  end

  icache_rr_arb #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_rr_arb (
    .req   (pending_q),
    .ptr   (rr_ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign win_line = line_q[win_q];
  assign in_upd   = (state_q == ST_UPD);

  always_comb begin
    same_line = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      same_line[p] = (line_q[p] == win_line);
    end
  end

  // Cores answered by this refill; the winner is always included.
  assign serve = win_gnt_q | ((MERGE_EN != 0) ? (pending_q & same_line) : '0);
  assign clear = in_upd ? serve : '0;
  // A miss is accepted on an idle core, or on a core whose pending bit is
  // clearing at this very edge (set beats clear).
  assign set       = i_cache_miss & (~pending_q | clear);
  assign pending_d = (pending_q & ~clear) | set;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (arb_valid)   state_d = ST_REQ;
      ST_REQ:  if (i_mm_gnt)    state_d = ST_WAIT;
      ST_WAIT: if (i_mm_rvalid) state_d = ST_UPD;
      ST_UPD:                   state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pending_q <= '0;
      line_q    <= '0;
      vic_q     <= '0;
      rr_ptr_q  <= '0;
      win_q     <= '0;
      win_gnt_q <= '0;
      data_q    <= '0;
      resp_q    <= '0;
    end else begin
      pending_q <= pending_d;
      for (int p = 0; p < NUM_PE; p++) begin
        if (set[p]) begin
          line_q[p] <= i_addr_miss[p][31:OFF];
          vic_q[p]  <= i_vic_miss[p];
        end
      end
      // Winner is frozen for the whole refill.
      if (state_q == ST_IDLE && arb_valid) begin
        win_q     <= arb_idx;
        win_gnt_q <= arb_gnt;
      end
      if (state_q == ST_WAIT && i_mm_rvalid) begin
        data_q <= i_mm_rdata;
      end
      // Response lands the cycle after UPD, together with the pending clear.
      resp_q <= clear;
      if (in_upd) begin
        rr_ptr_q <= (win_q == IDX_W'(NUM_PE - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------ outputs
  assign o_resp_miss = resp_q;
  assign o_mm_rden   = (state_q == ST_REQ);
  assign o_mm_addr   = (state_q == ST_REQ) ? {win_line, {OFF{1'b0}}} : '0;

  assign o_inst_tag_upd        = in_upd ? vic_q[win_q] : '0;
  assign o_inst_tag_addr_upd   = in_upd ? win_line[0 +: ADDR_WIDTH] : '0;
  assign o_inst_tag_wdata_upd  = in_upd ? {1'b1, win_line[ADDR_WIDTH +: TAG_WIDTH-1]} : '0;
  assign o_inst_data_wdata_upd = in_upd ? data_q : '0;

  assign o_busy = (state_q != ST_IDLE) || (|pending_q);

endmodule

// File: tb/tb_icache_refill_arb.sv
// -----------------------------------------------------------------------------
// tb_icache_refill_arb
// Directed bench for icache_refill_arb. Two instances share all inputs: dut
// (MERGE_EN=1) is the main target, dut_nm (MERGE_EN=0) is only inspected in
// the same-line merge scenario.
// -----------------------------------------------------------------------------
module tb_icache_refill_arb;

  localparam int NUM_PE     = 4;
  localparam int ADDR_WIDTH = 6;
  localparam int TAG_WIDTH  = 8;
  localparam int DATA_WIDTH = 128;
  localparam int N_WAY      = 4;

  // ------------------------------------------------ clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst_n;
  logic [NUM_PE-1:0]            cache_miss;
  logic [NUM_PE-1:0][31:0]      addr_miss;
  logic [NUM_PE-1:0][N_WAY-1:0] vic_miss;
  logic                         mm_gnt;
  logic [DATA_WIDTH-1:0]        mm_rdata;
  logic                         mm_rvalid;

  logic [NUM_PE-1:0]     resp;
  logic                  mm_rden;
  logic [31:0]           mm_addr;
  logic [N_WAY-1:0]      tag_upd;
  logic [ADDR_WIDTH-1:0] tag_addr_upd;
  logic [TAG_WIDTH-1:0]  tag_wdata;
  logic [DATA_WIDTH-1:0] data_wdata;
  logic                  busy;

  logic [NUM_PE-1:0]     nm_resp;
  logic                  nm_mm_rden;
  logic [31:0]           nm_mm_addr;
  logic [N_WAY-1:0]      nm_tag_upd;
  logic [ADDR_WIDTH-1:0] nm_tag_addr_upd;
  logic [TAG_WIDTH-1:0]  nm_tag_wdata;
  logic [DATA_WIDTH-1:0] nm_data_wdata;
  logic                  nm_busy;

  icache_refill_arb #(
    .NUM_PE(NUM_PE), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .N_WAY(N_WAY), .MERGE_EN(1)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cache_miss(cache_miss), .i_addr_miss(addr_miss), .i_vic_miss(vic_miss),
    .o_resp_miss(resp), .o_mm_rden(mm_rden), .o_mm_addr(mm_addr),
    .i_mm_gnt(mm_gnt), .i_mm_rdata(mm_rdata), .i_mm_rvalid(mm_rvalid),
    .o_inst_tag_upd(tag_upd), .o_inst_tag_addr_upd(tag_addr_upd),
    .o_inst_tag_wdata_upd(tag_wdata), .o_inst_data_wdata_upd(data_wdata),
    .o_busy(busy)
  );

  icache_refill_arb #(
    .NUM_PE(NUM_PE), .ADDR_WIDTH(ADDR_WIDTH), .TAG_WIDTH(TAG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .N_WAY(N_WAY), .MERGE_EN(0)
  ) dut_nm (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cache_miss(cache_miss), .i_addr_miss(addr_miss), .i_vic_miss(vic_miss),
    .o_resp_miss(nm_resp), .o_mm_rden(nm_mm_rden), .o_mm_addr(nm_mm_addr),
    .i_mm_gnt(mm_gnt), .i_mm_rdata(mm_rdata), .i_mm_rvalid(mm_rvalid),
    .o_inst_tag_upd(nm_tag_upd), .o_inst_tag_addr_upd(nm_tag_addr_upd),
    .o_inst_tag_wdata_upd(nm_tag_wdata), .o_inst_data_wdata_upd(nm_data_wdata),
    .o_busy(nm_busy)
  );

  // ------------------------------------------------ scoreboard state
  int checks   = 0;
  int failures = 0;
  int rden_cnt;
  int nm_rden_cnt;
  int nm_resp_cnt;
  logic [NUM_PE-1:0] exp_q[$];
  logic              quiet_bad;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ------------------------------------------------ driver tasks
  // Advance one cycle; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic miss(input logic [1:0] p, input logic [31:0] a, input logic [N_WAY-1:0] v);
    cache_miss[p] = 1'b1;
    addr_miss[p]  = a;
    vic_miss[p]   = v;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    cache_miss = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Run n cycles, matching each response pulse of dut against exp_q and
  // counting memory requests / responses of both instances.
  task automatic collect(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (mm_rden)    rden_cnt++;
      if (nm_mm_rden) nm_rden_cnt++;
      if (nm_resp != '0) nm_resp_cnt++;
      if (resp != '0) begin
        if (exp_q.size() == 0) check("resp_unexpected", resp, 0);
        else                   check("resp_order", resp, exp_q.pop_front());
      end
    end
  endtask

  // ------------------------------------------------ directed sequence
  initial begin
    cache_miss = '0;
    addr_miss  = '0;
    vic_miss   = '0;
    mm_gnt     = 1'b1;
    mm_rvalid  = 1'b1;
    mm_rdata   = 128'h0123456789abcdef_fedcba9876543210;

    // Reset state
    do_reset();
    check("rst_rden", mm_rden, 0);
    check("rst_addr", mm_addr, 0);
    check("rst_resp", resp, 0);
    check("rst_tag_upd", tag_upd, 0);
    check("rst_busy", busy, 0);

    // Single miss, immediate gnt/rvalid: rden t+2, UPD t+4, resp t+5
    miss(0, 32'h0000_1234, 4'b0010);
    tick();                                  // t+1
    cache_miss = '0;
    check("lat_t1_rden", mm_rden, 0);
    check("lat_t1_busy", busy, 1);
    tick();                                  // t+2
    check("lat_t2_rden", mm_rden, 1);
    check("lat_t2_addr", mm_addr, 32'h0000_1230);
    tick();                                  // t+3 WAIT
    check("lat_t3_tag_upd", tag_upd, 0);
    tick();                                  // t+4 UPD
    check("upd_tag_upd", tag_upd, 4'b0010);
    check("upd_addr", tag_addr_upd, 6'h23);
    check("upd_tag_wdata", tag_wdata, 8'h84);
    check("upd_data", data_wdata, 128'h0123456789abcdef_fedcba9876543210);
    check("upd_resp_early", resp, 0);
    tick();                                  // t+5
    check("resp_t5", resp, 4'b0001);
    check("resp_t5_tag_upd", tag_upd, 0);
    tick();
    check("resp_pulse_end", resp, 0);
    check("single_idle_busy", busy, 0);

    // Round-robin: four distinct lines, then PE3+PE0 after wrap
    do_reset();
    rden_cnt = 0; nm_rden_cnt = 0; nm_resp_cnt = 0;
    exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    miss(0, 32'h0000_1000, 4'b0001);
    miss(1, 32'h0000_2000, 4'b0010);
    miss(2, 32'h0000_3000, 4'b0100);
    miss(3, 32'h0000_4000, 4'b1000);
    tick();
    cache_miss = '0;
    collect(20);
    check("rr_all_served", exp_q.size(), 0);
    check("rr_fetch_cnt", rden_cnt, 4);
    exp_q = '{4'b0001, 4'b1000};
    miss(3, 32'h0000_6000, 4'b0001);
    miss(0, 32'h0000_5000, 4'b0001);
    tick();
    cache_miss = '0;
    collect(12);
    check("rr_wrap_served", exp_q.size(), 0);

    // Same-line merge: one fetch with merge, two without
    do_reset();
    rden_cnt = 0; nm_rden_cnt = 0; nm_resp_cnt = 0;
    exp_q = '{4'b0110};
    miss(1, 32'h0000_0100, 4'b0001);
    miss(2, 32'h0000_010C, 4'b0010);
    tick();
    cache_miss = '0;
    collect(14);
    check("merge_served", exp_q.size(), 0);
    check("merge_fetch_cnt", rden_cnt, 1);
    check("nomerge_fetch_cnt", nm_rden_cnt, 2);
    check("nomerge_resp_cnt", nm_resp_cnt, 2);

    // Grant held low 5 cycles in REQ, rvalid during REQ ignored
    do_reset();
    mm_gnt    = 1'b0;
    mm_rvalid = 1'b1;
    mm_rdata  = {4{32'haaaa_5555}};
    miss(2, 32'h0000_ABC7, 4'b0100);
    tick();
    cache_miss = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_rden", mm_rden, 1);
      check("stall_addr", mm_addr, 32'h0000_ABC0);
      check("stall_tag_upd", tag_upd, 0);
    end
    mm_gnt    = 1'b1;
    mm_rvalid = 1'b0;
    tick();                                  // WAIT
    check("stall_wait_rden", mm_rden, 0);
    mm_rvalid = 1'b1;
    mm_rdata  = {4{32'h1357_9bdf}};
    tick();                                  // UPD
    check("stall_upd_tag_upd", tag_upd, 4'b0100);
    check("stall_upd_addr", tag_addr_upd, 6'h3C);
    check("stall_upd_tag_wdata", tag_wdata, 8'hAA);
    check("stall_upd_data", data_wdata, {4{32'h1357_9bdf}});
    tick();
    check("stall_resp", resp, 4'b0100);

    // Reset in WAIT, stale rvalid afterwards
    do_reset();
    mm_gnt    = 1'b1;
    mm_rvalid = 1'b0;
    miss(3, 32'h0000_5550, 4'b1000);
    tick();
    cache_miss = '0;
    tick();                                  // REQ
    tick();                                  // WAIT
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    tick();
    check("abort_rden", mm_rden, 0);
    check("abort_busy", busy, 0);
    rst_n     = 1'b1;
    mm_rvalid = 1'b1;
    quiet_bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (tag_upd != '0 || resp != '0 || mm_rden || busy) quiet_bad = 1'b1;
    end
    check("abort_quiet", quiet_bad, 0);

    // Repeat miss while pending ignored; miss in resp cycle re-issued
    do_reset();
    miss(0, 32'h0000_0040, 4'b0001);
    tick();                                  // t+1
    miss(0, 32'h0000_0080, 4'b0010);         // repeat while pending
    tick();                                  // t+2
    cache_miss = '0;
    check("repeat_req_addr", mm_addr, 32'h0000_0040);
    tick();                                  // t+3
    tick();                                  // t+4 UPD
    check("repeat_upd_addr", tag_addr_upd, 6'h04);
    check("repeat_upd_vic", tag_upd, 4'b0001);
    tick();                                  // t+5
    check("repeat_resp", resp, 4'b0001);
    miss(0, 32'h0000_0200, 4'b0100);         // same cycle as resp
    tick();                                  // t+6
    cache_miss = '0;
    check("rearm_resp_clear", resp, 0);
    check("rearm_busy", busy, 1);
    tick();                                  // t+7 REQ
    check("rearm_req_addr", mm_addr, 32'h0000_0200);
    exp_q = '{4'b0001};
    collect(6);
    check("rearm_served", exp_q.size(), 0);

    // Miss during UPD of the same core is kept (set beats clear)
    do_reset();
    miss(1, 32'h0000_0500, 4'b0001);
    tick();
    cache_miss = '0;
    tick();                                  // t+2 REQ
    tick();                                  // t+3 WAIT
    tick();                                  // t+4 UPD
    check("setwin_upd_addr", tag_addr_upd, 6'h10);
    miss(1, 32'h0000_0700, 4'b0010);
    tick();                                  // t+5
    cache_miss = '0;
    check("setwin_resp", resp, 4'b0010);
    check("setwin_busy", busy, 1);
    tick();                                  // t+6 REQ
    check("setwin_rden", mm_rden, 1);
    check("setwin_addr", mm_addr, 32'h0000_0700);
    exp_q = '{4'b0010};
    collect(6);
    check("setwin_served", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
